entrada_operandos: RTL and testbench

Operand-entry sequencer that sits directly upstream of the 4-bit adder/subtractor and its 7-segment display path. It captures operand A, operand B and the add/subtract select from the board switches on debounced pushbutton presses. It then holds them stable on its outputs for the combinational adder. A small FSM walks the user through A, then B, then showing the result.

---
 rtl/entrada_operandos_pkg.sv | 15 +
 rtl/entrada_operandos_debounce_tecla.sv | 111 +++++++++++
 rtl/entrada_operandos.sv | 119 +++++++++++
 tb/tb_entrada_operandos.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/entrada_operandos_pkg.sv
// entrada_operandos_pkg: state codes and default constants shared by the
// operand-entry sequencer and its pushbutton conditioner.
package entrada_operandos_pkg;

    // 20 ms of key stability at 50 MHz.
    localparam int DEB_CYCLES_DEF = 1000000;

    // Encodings are visible on the LEDs; 2'b11 is unused.
    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        SHOW  = 2'b10
    } state_t;

endpackage : entrada_operandos_pkg

// File: rtl/entrada_operandos_debounce_tecla.sv
// debounce_tecla: conditions one active-low pushbutton into a single-cycle
// press pulse. Two-flop synchronizer, optional debounce counter (present only
// when ENTRADA_DEBOUNCE_EN is defined), then a registered falling-edge pulse.
// A key already held when reset is released is ignored until it has been seen
// released at least once.
module debounce_tecla
    import entrada_operandos_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic sync1_d, sync1_q;
    logic sync2_d, sync2_q;
    logic stable;
    logic lvl_d, lvl_q;
    logic lvl_prev_d, lvl_prev_q;
    logic armed_d, armed_q;
    logic press_d, press_q;

    // Synchronizer next values. The chain resets to 0 ("possibly pressed") so
    // that only a genuinely sampled high level can arm the press detector.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge value of its neighbour, which is what makes this a
            // two-stage shift rather than a single wire.
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef ENTRADA_DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             stable_d, stable_q;

    // Count consecutive cycles of disagreement; adopt the new level once the
    // count has reached DEB_CYCLES-1 and the levels still differ.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the ifs leaves it unassigned (no latch).
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state: stable level starts released, counter at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
`else
    // Clean-signal build: the synchronizer feeds edge detection directly.
    assign stable = sync2_q;
`endif

    // Edge detector and arming: a falling edge of the registered level gives
    // one pulse, but only after the key has been observed released.
    always_comb begin
        lvl_d      = stable;
        lvl_prev_d = lvl_q;
        armed_d    = armed_q | sync2_q;
        press_d    = armed_q & lvl_prev_q & ~lvl_q;
    end

    // Edge detector flops; levels reset to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q      <= 1'b1;
            lvl_prev_q <= 1'b1;
            armed_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            armed_q    <= armed_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule : debounce_tecla

// File: rtl/entrada_operandos.sv
// entrada_operandos: operand-entry sequencer ahead of the 4-bit
// adder/subtractor. Captures A, B and add/sub from the switches on enter
// presses and holds them for the combinational adder. Define
// ENTRADA_DEBOUNCE_EN to include the pushbutton debounce counters.
module entrada_operandos
    import entrada_operandos_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             key_enter_n,
    input  logic             key_clear_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_op,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_sub,
    output logic             op_valid,
    output logic             result_load,
    output logic [1:0]       state_code
);

    logic enter_press;
    logic clear_press;

    debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_n (key_enter_n),
        .press (enter_press)
    );

    debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_n (key_clear_n),
        .press (clear_press)
    );

    state_t           state_d, state_q;
    logic [WIDTH-1:0] op_a_d, op_a_q;
    logic [WIDTH-1:0] op_b_d, op_b_q;
    logic             op_sub_d, op_sub_q;
    logic             op_valid_d, op_valid_q;
    logic             result_load_d, result_load_q;

    // Next state and operand captures; clear overrides a simultaneous enter.
    // The switches are looked at only in a press cycle.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_sub_d = op_sub_q;
        if (clear_press) begin
            state_d  = GET_A;
            op_a_d   = '0;
            op_b_d   = '0;
            op_sub_d = 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (enter_press) begin
                        op_a_d  = sw_data;
                        op_b_d  = '0;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (enter_press) begin
                        op_b_d   = sw_data;
                        op_sub_d = sw_op;
                        state_d  = SHOW;
                    end
                end
                SHOW: begin
                    if (enter_press) begin
                        op_a_d  = sw_data;
                        op_b_d  = '0;
                        state_d = GET_B;
                    end
                end
                default: state_d = GET_A;
            endcase
        end
        // Registered decodes of the next state keep the status outputs
        // glitch-free and aligned with state_code.
        op_valid_d    = (state_d == SHOW);
        result_load_d = (state_d == SHOW) && (state_q != SHOW);
    end

    // State and operand registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= GET_A;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_sub_q      <= 1'b0;
            op_valid_q    <= 1'b0;
            result_load_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_sub_q      <= op_sub_d;
            op_valid_q    <= op_valid_d;
            result_load_q <= result_load_d;
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_sub      = op_sub_q;
    assign op_valid    = op_valid_q;
    assign result_load = result_load_q;
    assign state_code  = state_q;

endmodule : entrada_operandos

// File: tb/tb_entrada_operandos.sv
// tb_entrada_operandos: directed bench for the operand-entry sequencer with
// DEB_CYCLES=4. Press latency and bounce expectations follow the build
// (ENTRADA_DEBOUNCE_EN defined or not).
`timescale 1ns/1ps
module tb_entrada_operandos;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;
`ifdef ENTRADA_DEBOUNCE_EN
    localparam int LAT = DEB + 4;
`else
    localparam int LAT = 4;
`endif
    localparam int HOLD   = LAT + 4;
    localparam int SETTLE = LAT + 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             key_enter_n = 1'b1;
    logic             key_clear_n = 1'b1;
    logic [WIDTH-1:0] sw_data = '0;
    logic             sw_op = 1'b0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             op_valid;
    logic             result_load;
    logic [1:0]       state_code;

    entrada_operandos #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .sw_data     (sw_data),
        .sw_op       (sw_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_sub      (op_sub),
        .op_valid    (op_valid),
        .result_load (result_load),
        .state_code  (state_code)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic esub, input logic evalid, input logic [1:0] est);
        check({tag, ".op_a"},       32'(op_a),       32'(ea));
        check({tag, ".op_b"},       32'(op_b),       32'(eb));
        check({tag, ".op_sub"},     32'(op_sub),     32'(esub));
        check({tag, ".op_valid"},   32'(op_valid),   32'(evalid));
        check({tag, ".state_code"}, 32'(state_code), 32'(est));
    endtask

    // One press of enter and/or clear: keys low for 'hold' cycles, then
    // released and given time for the release to pass the conditioner.
    task automatic press(input logic en, input logic cl, input logic [3:0] d,
                         input logic o, input int hold);
        @(negedge clk);
        sw_data = d;
        sw_op   = o;
        if (en) key_enter_n = 1'b0;
        if (cl) key_clear_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (SETTLE) @(negedge clk);
    endtask

    // result_load must be high exactly on the first sample where op_valid is 1.
    int   rl_pulses = 0;
    int   rl_bad    = 0;
    int   exp_rl    = 0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (result_load === 1'b1) rl_pulses++;
        if (result_load !== (op_valid && !valid_prev)) rl_bad++;
        valid_prev = op_valid;
    end

    typedef struct {
        logic       is_clear;
        logic [3:0] sw;
        logic       op;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       esub;
        logic       evalid;
        logic [1:0] est;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Starting from GET_B with op_a=5 after the latency sequence.
        vecs[0] = '{1'b0, 4'h3, 1'b0, 4'h5, 4'h3, 1'b0, 1'b1, 2'b10}; // B=3 add -> SHOW
        vecs[1] = '{1'b0, 4'h9, 1'b1, 4'h9, 4'h0, 1'b0, 1'b0, 2'b01}; // restart A=9
        vecs[2] = '{1'b0, 4'h4, 1'b1, 4'h9, 4'h4, 1'b1, 1'b1, 2'b10}; // B=4 subtract
        vecs[3] = '{1'b0, 4'h2, 1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 2'b01}; // restart A=2
        vecs[4] = '{1'b1, 4'h7, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00}; // clear
        vecs[5] = '{1'b0, 4'hF, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 2'b01}; // A=F, op ignored
        vecs[6] = '{1'b0, 4'h0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 2'b10}; // B=0 subtract
        vecs[7] = '{1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00}; // clear from SHOW
        vecs[8] = '{1'b0, 4'h9, 1'b0, 4'h9, 4'h0, 1'b0, 1'b0, 2'b01}; // A=9

        // Reset values.
        #2 rst_n = 1'b0;
        #3;
        check_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        check("reset.result_load", 32'(result_load), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Press latency: edge 0 is the first edge seeing the key low.
        sw_data = 4'h5;
        sw_op   = 1'b0;
        key_enter_n = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check("latency.before", 32'(state_code), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency.at", 32'(state_code), 32'd1);
        check("latency.op_a", 32'(op_a), 32'h5);
        repeat (HOLD) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (SETTLE) @(negedge clk);

        // Table-driven sequence, plus switch changes that must be ignored.
        for (int i = 0; i < 9; i++) begin
            press(!vecs[i].is_clear, vecs[i].is_clear, vecs[i].sw, vecs[i].op, HOLD);
            if (vecs[i].est == 2'b10) exp_rl++;
            check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].esub,
                      vecs[i].evalid, vecs[i].est);
            sw_data = ~vecs[i].sw;
            sw_op   = ~vecs[i].op;
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d.sw_ignored_a", i), 32'(op_a), 32'(vecs[i].ea));
            check($sformatf("vec%0d.sw_ignored_b", i), 32'(op_b), 32'(vecs[i].eb));
        end

        // Clear and enter on the same edge in GET_B: clear wins.
        press(1'b1, 1'b1, 4'hA, 1'b1, HOLD);
        check_all("simul", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);

        // Held key: 100 cycles low gives one advance only.
        press(1'b1, 1'b0, 4'h6, 1'b0, 100);
        check_all("held", 4'h6, 4'h0, 1'b0, 1'b0, 2'b01);

`ifdef ENTRADA_DEBOUNCE_EN
        // Bounce: low 3, high 2, then steady low; one press timed from the
        // start of the steady low.
        @(negedge clk);
        sw_data = 4'h7;
        sw_op   = 1'b0;
        key_enter_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        key_enter_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        key_enter_n = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check("bounce.before", 32'(state_code), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bounce.at", 32'(state_code), 32'd2);
        check("bounce.result_load", 32'(result_load), 32'd1);
        @(negedge clk);
        check("bounce.result_load_end", 32'(result_load), 32'd0);
        exp_rl++;
        repeat (HOLD) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (SETTLE) @(negedge clk);
        check_all("bounce", 4'h6, 4'h7, 1'b0, 1'b1, 2'b10);
`endif

        // Reset mid-entry: into GET_B, then asynchronous reset between edges.
        press(1'b0, 1'b1, 4'h0, 1'b0, HOLD);
        press(1'b1, 1'b0, 4'hC, 1'b0, HOLD);
        check("mid.pre_state", 32'(state_code), 32'd1);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check_all("mid_reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        check("mid_reset.result_load", 32'(result_load), 32'd0);

        // Key held across reset release: no press until released and pressed.
        key_enter_n = 1'b0;
        sw_data = 4'hB;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("held_reset.state", 32'(state_code), 32'd0);
        key_enter_n = 1'b1;
        repeat (SETTLE) @(negedge clk);
        check("held_reset.after_release", 32'(state_code), 32'd0);
        press(1'b1, 1'b0, 4'hB, 1'b0, HOLD);
        check("held_reset.repress", 32'(state_code), 32'd1);
        check("held_reset.op_a", 32'(op_a), 32'hB);

        // result_load bookkeeping over the whole run.
        check("result_load.count", 32'(rl_pulses), 32'(exp_rl));
        check("result_load.aligned", 32'(rl_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_entrada_operandos
